// File: rtl/mmmul_stream_driver.sv
// mmmul_stream_driver: initiator-side controller for the mmmul matrix multiplier.
// Collects matrix1 then matrix2 from a float32 valid/ready stream, runs mmmul,
// captures the product and streams it back out row-major with a last flag.
// Optional watchdog on the RUN state: define MMMUL_DRV_TIMEOUT_EN.
module mmmul_stream_driver #(
  parameter int ROWS1          = 4,
  parameter int COLS1          = 4,
  parameter int ROWS2          = 4,
  parameter int COLS2          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [31:0]              s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_data,
  output logic                     m_last,
  output logic                     mm_enable,
  input  logic                     mm_done,
  output logic [ROWS1*COLS1*32-1:0] mm_matrix1,
  output logic [ROWS2*COLS2*32-1:0] mm_matrix2,
  input  logic [ROWS1*COLS2*32-1:0] mm_result,
  output logic                     busy,
  output logic                     error
);

  localparam int N1   = ROWS1 * COLS1;
  localparam int N2   = ROWS2 * COLS2;
  localparam int NR   = ROWS1 * COLS2;
  localparam int N12  = (N1 > N2) ? N1 : N2;
  localparam int NMAX = (N12 > NR) ? N12 : NR;
  localparam int CW   = $clog2(NMAX) + 1;

  typedef enum logic [2:0] {LOAD_A, LOAD_B, RUN, DRAIN, WAIT_CLR} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   idx;
  logic [NR*32-1:0] result;
  logic            in_hs, out_hs;
  logic            a_last, b_last, r_last;
  logic            timeout_hit;

  generate
    if (COLS1 != ROWS2) begin : g_dim_check
      $error("mmmul_stream_driver: COLS1 (%0d) must equal ROWS2 (%0d)", COLS1, ROWS2);
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("mmmul_stream_driver: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  assign in_hs  = s_valid && s_ready;
  assign out_hs = m_valid && m_ready;
  assign a_last = (idx == CW'(N1 - 1));
  assign b_last = (idx == CW'(N2 - 1));
  assign r_last = (idx == CW'(NR - 1));

`ifdef MMMUL_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt;

  assign timeout_hit = (state == RUN) && !mm_done && (run_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: count cycles spent in RUN and latch a sticky error on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      error   <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + TW'(1) : '0;
      if (timeout_hit) error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= next_state;
  end

  // Next-state: terminal element indices force each phase change
  always_comb begin
    next_state = state;
    case (state)
      LOAD_A:   if (in_hs && a_last) next_state = LOAD_B;
      LOAD_B:   if (in_hs && b_last) next_state = RUN;
      RUN: begin
        if (mm_done)          next_state = DRAIN;
        else if (timeout_hit) next_state = WAIT_CLR;
      end
      DRAIN:    if (out_hs && r_last) next_state = WAIT_CLR;
      WAIT_CLR: if (!mm_done) next_state = LOAD_A;
      default:  next_state = LOAD_A;
    endcase
  end

  // Element counter, matrix buffers and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      mm_matrix1 <= '0;
      mm_matrix2 <= '0;
      result     <= '0;
    end else begin
      case (state)
        LOAD_A: if (in_hs) begin
          for (int i = 0; i < N1; i++)
            if (idx == CW'(i)) mm_matrix1[i*32 +: 32] <= s_data;
          idx <= a_last ? '0 : idx + CW'(1);
        end
        LOAD_B: if (in_hs) begin
          for (int i = 0; i < N2; i++)
            if (idx == CW'(i)) mm_matrix2[i*32 +: 32] <= s_data;
          idx <= b_last ? '0 : idx + CW'(1);
        end
        RUN: begin
          idx <= '0;
          if (mm_done) result <= mm_result;
        end
        DRAIN: if (out_hs) idx <= r_last ? '0 : idx + CW'(1);
        default: idx <= '0;
      endcase
    end
  end

  // Outputs decoded from state; result word selected by the element counter
  always_comb begin
    s_ready   = (state == LOAD_A) || (state == LOAD_B);
    mm_enable = (state == RUN);
    m_valid   = (state == DRAIN);
    m_last    = (state == DRAIN) && r_last;
    busy      = !((state == LOAD_A) && (idx == '0));
    m_data    = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < NR; i++)
        if (idx == CW'(i)) m_data = result[i*32 +: 32];
    end
  end

endmodule

// File: tb/tb_mmmul_stream_driver.sv
// tb_mmmul_stream_driver: directed and randomized jobs for mmmul_stream_driver.
// A behavioural mmmul (integer-valued floats, plain arithmetic) answers the
// driver; expected results are the matrix product of the words the bench sent.
module tb_mmmul_stream_driver;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  // 4x4 driver
  logic         s_valid, s_ready, m_valid, m_ready, m_last;
  logic [31:0]  s_data, m_data;
  logic         mm_enable, mm_done, busy, error;
  logic [511:0] mm_matrix1, mm_matrix2, mm_result;

  // 2x3 * 3x2 driver
  logic         sm_s_valid, sm_s_ready, sm_m_valid, sm_m_ready, sm_m_last;
  logic [31:0]  sm_s_data, sm_m_data;
  logic         sm_mm_enable, sm_mm_done, sm_busy, sm_error;
  logic [191:0] sm_mm_matrix1, sm_mm_matrix2;
  logic [127:0] sm_mm_result;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sm_expected [4] = '{32'h40800000, 32'h40A00000, 32'h41200000, 32'h41300000};

  mmmul_stream_driver #(
    .ROWS1(4), .COLS1(4), .ROWS2(4), .COLS2(4), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mm_enable(mm_enable), .mm_done(mm_done),
    .mm_matrix1(mm_matrix1), .mm_matrix2(mm_matrix2), .mm_result(mm_result),
    .busy(busy), .error(error)
  );

  mmmul_stream_driver #(
    .ROWS1(2), .COLS1(3), .ROWS2(3), .COLS2(2), .TIMEOUT_CYCLES(16)
  ) u_small (
    .clk(clk), .rst(rst),
    .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_data(sm_s_data),
    .m_valid(sm_m_valid), .m_ready(sm_m_ready), .m_data(sm_m_data), .m_last(sm_m_last),
    .mm_enable(sm_mm_enable), .mm_done(sm_mm_done),
    .mm_matrix1(sm_mm_matrix1), .mm_matrix2(sm_mm_matrix2), .mm_result(sm_mm_result),
    .busy(sm_busy), .error(sm_error)
  );

  // Non-negative integer to float32 bits (exact for small values)
  function automatic logic [31:0] i2f(input int v);
    int msb;
    logic [31:0] u;
    if (v <= 0) return 32'h0;
    msb = 0;
    for (int k = 0; k < 31; k++) if (v[k]) msb = k;
    u = 32'(v) << (23 - msb);
    return {1'b0, 8'(127 + msb), u[22:0]};
  endfunction

  // Integer-valued float32 bits back to an integer
  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    if (e >= 23) return int'(m) << (e - 23);
    return int'(m >> (23 - e));
  endfunction

  // Behavioural mmmul: product of the packed matrices the driver presents
  function automatic logic [511:0] mmmul_model(input logic [511:0] m1, input logic [511:0] m2,
                                               input int r1, input int c1, input int c2);
    logic [511:0] res;
    int acc;
    res = '0;
    for (int r = 0; r < r1; r++)
      for (int c = 0; c < c2; c++) begin
        acc = 0;
        for (int k = 0; k < c1; k++)
          acc += f2i(m1[(r*c1+k)*32 +: 32]) * f2i(m2[(k*c2+c)*32 +: 32]);
        res[(r*c2+c)*32 +: 32] = i2f(acc);
      end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) checkOutput("push_ready_timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic push_small(input logic [31:0] d);
    int guard;
    guard = 0;
    sm_s_valid = 1'b1;
    sm_s_data  = d;
    while (sm_s_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) checkOutput("sm_push_ready_timeout", sm_s_ready, 1);
    @(negedge clk);
    sm_s_valid = 1'b0;
  endtask

  // One full 4x4 job: load, mmmul answers after 10 enabled cycles, drain, clear
  task automatic applyStimulus(input int a[16], input int b[16], input bit stall, input int hold);
    logic [511:0] exp_m1, exp_m2;
    int c[16];
    int beat, cyc;
    bit held;
    logic [31:0] held_data;
    logic held_last;
    exp_m1 = '0;
    exp_m2 = '0;
    for (int i = 0; i < N; i++) begin
      exp_m1[i*32 +: 32] = i2f(a[i]);
      exp_m2[i*32 +: 32] = i2f(b[i]);
    end
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        c[r*4+q] = 0;
        for (int k = 0; k < 4; k++) c[r*4+q] += a[r*4+k] * b[k*4+q];
      end

    for (int i = 0; i < N; i++) push(i2f(a[i]));
    for (int i = 0; i < N; i++) push(i2f(b[i]));

    checkOutput("enable_after_load", mm_enable, 1);
    checkOutput("sready_in_run", s_ready, 0);
    checkOutput("busy_in_run", busy, 1);
    checkOutput("matrix1_packing", mm_matrix1, exp_m1);
    checkOutput("matrix2_packing", mm_matrix2, exp_m2);

    repeat (9) begin
      @(negedge clk);
      checkOutput("enable_held", mm_enable, 1);
      checkOutput("no_valid_in_run", m_valid, 0);
    end
    mm_result = mmmul_model(mm_matrix1, mm_matrix2, 4, 4, 4);
    mm_done   = 1'b1;
    @(negedge clk);
    checkOutput("enable_drop", mm_enable, 0);
    checkOutput("first_valid", m_valid, 1);
    if (hold == 0) mm_done = 1'b0;

    beat = 0;
    cyc  = 0;
    held = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (beat < N && cyc < 100) begin
      m_ready = (stall && cyc[0]) ? 1'b0 : 1'b1;
      checkOutput("beat_valid", m_valid, 1);
      if (held) begin
        checkOutput("stall_data", m_data, held_data);
        checkOutput("stall_last", m_last, held_last);
      end
      if (m_ready) begin
        checkOutput($sformatf("beat%0d_data", beat), m_data, i2f(c[beat]));
        checkOutput($sformatf("beat%0d_last", beat), m_last, beat == N - 1);
        beat++;
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_data = m_data;
        held_last = m_last;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    checkOutput("beat_count", beat, N);
    checkOutput("valid_after_last", m_valid, 0);
    checkOutput("sready_wait_clr", s_ready, 0);

    repeat (hold) begin
      @(negedge clk);
      checkOutput("sready_while_done", s_ready, 0);
      checkOutput("valid_while_done", m_valid, 0);
    end
    mm_done = 1'b0;
    @(negedge clk);
    checkOutput("sready_next_job", s_ready, 1);
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin
    int a[16], b[16];
    logic [511:0] sm_res;

    // Reset asserted from time zero: everything quiet
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; mm_done = 1'b0; mm_result = '0;
    sm_s_valid = 1'b0; sm_s_data = '0; sm_m_ready = 1'b0; sm_mm_done = 1'b0; sm_mm_result = '0;
    #2;
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_mm_enable", mm_enable, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_m_last", m_last, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("reset_matrix1", mm_matrix1, 0);
    checkOutput("reset_matrix2", mm_matrix2, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("idle_s_ready", s_ready, 1);

    // Identity x identity, downstream always ready
    $display("[TB] identity job, m_ready held high");
    for (int i = 0; i < N; i++) begin a[i] = (i % 5 == 0) ? 1 : 0; b[i] = a[i]; end
    applyStimulus(a, b, 1'b0, 0);

    // Same load with back-pressure every other cycle
    $display("[TB] identity job, m_ready toggling");
    applyStimulus(a, b, 1'b1, 0);

    // Partial load of matrix1 then reset pulse between edges
    $display("[TB] partial load aborted by reset");
    for (int i = 0; i < 10; i++) push(i2f(int'($urandom_range(1, 7))));
    checkOutput("busy_partial", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_matrix1", mm_matrix1, 0);
    checkOutput("abort_m_valid", m_valid, 0);
    checkOutput("abort_mm_enable", mm_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin a[i] = (i % 5 == 0) ? 2 : 0; b[i] = (i % 5 == 0) ? 1 : 0; end
    applyStimulus(a, b, 1'b0, 0);

    // Randomized jobs, one with mm_done held 5 cycles past the drain
    $display("[TB] randomized jobs");
    for (int i = 0; i < N; i++) begin a[i] = int'($urandom_range(0, 7)); b[i] = int'($urandom_range(0, 7)); end
    applyStimulus(a, b, 1'b0, 5);
    for (int i = 0; i < N; i++) begin a[i] = int'($urandom_range(0, 7)); b[i] = int'($urandom_range(0, 7)); end
    applyStimulus(a, b, 1'b1, 0);
    for (int i = 0; i < N; i++) begin a[i] = int'($urandom_range(0, 7)); b[i] = int'($urandom_range(0, 7)); end
    applyStimulus(a, b, 1'b0, 0);

    // Non-square geometry: [[1,2,3],[4,5,6]] x [[1,0],[0,1],[1,1]]
    $display("[TB] 2x3 by 3x2 job");
    push_small(i2f(1)); push_small(i2f(2)); push_small(i2f(3));
    push_small(i2f(4)); push_small(i2f(5)); push_small(i2f(6));
    push_small(i2f(1)); push_small(i2f(0));
    push_small(i2f(0)); push_small(i2f(1));
    push_small(i2f(1)); push_small(i2f(1));
    checkOutput("sm_enable", sm_mm_enable, 1);
    repeat (3) @(negedge clk);
    sm_res = mmmul_model({320'b0, sm_mm_matrix1}, {320'b0, sm_mm_matrix2}, 2, 3, 2);
    sm_mm_result = sm_res[127:0];
    sm_mm_done = 1'b1;
    @(negedge clk);
    sm_mm_done = 1'b0;
    sm_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sm_beat%0d_valid", i), sm_m_valid, 1);
      checkOutput($sformatf("sm_beat%0d_data", i), sm_m_data, sm_expected[i]);
      checkOutput($sformatf("sm_beat%0d_last", i), sm_m_last, i == 3);
      @(negedge clk);
    end
    sm_m_ready = 1'b0;
    checkOutput("sm_valid_after_last", sm_m_valid, 0);
    @(negedge clk);
    checkOutput("sm_sready_next_job", sm_s_ready, 1);

`ifdef MMMUL_DRV_TIMEOUT_EN
    // Watchdog: mm_done never rises
    $display("[TB] watchdog expiry");
    for (int i = 0; i < 2 * N; i++) push(i2f((i % 5 == 0) ? 1 : 0));
    repeat (15) begin
      @(negedge clk);
      checkOutput("wd_valid_quiet", m_valid, 0);
    end
    checkOutput("wd_error_before", error, 0);
    checkOutput("wd_enable_before", mm_enable, 1);
    @(negedge clk);
    checkOutput("wd_error_set", error, 1);
    checkOutput("wd_enable_drop", mm_enable, 0);
    checkOutput("wd_no_valid", m_valid, 0);
    @(negedge clk);
    checkOutput("wd_back_to_load", s_ready, 1);
    checkOutput("wd_error_sticky", error, 1);
`else
    checkOutput("error_tied_low", error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmmul_stream_driver.md
Name: mmmul_stream_driver

Overview:
- Initiator-side controller for the mmmul matrix multiplier.
- Accepts a serial valid/ready stream of IEEE-754 single-precision words.
- Packs the first ROWS1*COLS1 words into matrix1 and the next ROWS2*COLS2 words into matrix2, then starts mmmul and waits for done.
- Captures the result and streams it back out element by element, with a last-flag on the final element.

Parameters:
- ROWS1, 4, rows of matrix1 and of result
- COLS1, 4, columns of matrix1; must equal ROWS2
- ROWS2, 4, rows of matrix2
- COLS2, 4, columns of matrix2 and of result
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN; used only with MMMUL_DRV_TIMEOUT_EN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  driver can accept an input word
- s_data  in  32  input float32 bits, row-major: all of matrix1, then all of matrix2
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts output word
- m_data  out  32  result float32 bits, row-major
- m_last  out  1  high with the final result element (index ROWS1*COLS2-1)
- mm_enable  out  1  start/hold request to mmmul
- mm_done  in  1  mmmul completion, level
- mm_matrix1  out  ROWS1*COLS1*32  element [r][c] at bits (r*COLS1+c)*32 +: 32
- mm_matrix2  out  ROWS2*COLS2*32  element [r][c] at bits (r*COLS2+c)*32 +: 32
- mm_result  in  ROWS1*COLS2*32  same packing as mm_matrix2, with width COLS2
- busy  out  1  high in every state except LOAD_A with count 0
- error  out  1  sticky watchdog flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous assert on rst=1, released synchronously to clk) forces:
  - state=LOAD_A, element counter=0
  - all outputs 0, including the matrix buffers and captured result
- States and transitions:
  - LOAD_A: s_ready=1. Each s_valid&s_ready handshake writes s_data into matrix1[idx] and increments idx. On idx=ROWS1*COLS1-1 → LOAD_B, idx=0.
  - LOAD_B: same, writing matrix2. On the last element → RUN, idx=0.
  - RUN: s_ready=0, mm_enable=1. The first cycle with mm_done=1 copies mm_result into the internal result buffer → DRAIN. mm_enable drops to 0 in the DRAIN entry cycle.
  - DRAIN: m_valid=1, m_data=result[idx]. On m_valid&m_ready, idx++. The handshake at idx=ROWS1*COLS2-1 has m_last=1 → WAIT_CLR.
  - WAIT_CLR: all outputs idle. Stay while mm_done=1; on mm_done=0 → LOAD_A, idx=0.
- mm_done high while in LOAD_A/LOAD_B is ignored.
- Latency:
  - mm_enable rises the cycle after the final matrix2 handshake.
  - First m_valid comes 1 cycle after mm_done is sampled high.
- m_data/m_last stay stable while m_valid=1 and m_ready=0. No bubbles are inserted between output beats when m_ready is held high.
- Input and output never overlap. s_ready=0 from RUN through WAIT_CLR.
- mm_matrix1/mm_matrix2 hold their values from the final load through RUN and keep them until overwritten in the next load.
- Counter width is $clog2 of the largest element count plus 1. Counters never wrap; the terminal index forces the state change.
- Reset mid-operation (any state): immediate return to the reset values. A partially loaded matrix is discarded.
- Elaboration: $error if COLS1 != ROWS2.

Optional Feature:
- Macro: MMMUL_DRV_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN.
  - If it reaches TIMEOUT_CYCLES without mm_done, then error=1 (sticky until rst), mm_enable drops, and the state goes to WAIT_CLR. No output beats are produced.
- Undefined: no counter; RUN waits indefinitely; error is constant 0.

Test Plan:
- 4x4 identity × identity; mm_done model asserts 10 cycles after enable; m_ready=1 → 16 beats, 0x3F800000 at indices 0,5,10,15 and 0x00000000 elsewhere; m_last only on beat 16; mm_enable high exactly from the cycle after the 32nd input until the cycle mm_done is sampled.
- Same load, m_ready toggled 1/0 each cycle → m_data/m_last unchanged across stalled cycles; still exactly 16 beats, same values.
- s_valid high for only 10 words, then rst pulsed mid-cycle → outputs 0 immediately; a fresh 32-word load then produces a correct product (A=2.0·I (0x40000000), B=I → diagonal 0x40000000).
- Parameters ROWS1=2, COLS1=3, ROWS2=3, COLS2=2: A=[[1,2,3],[4,5,6]], B=[[1,0],[0,1],[1,1]] → output 4,5,10,11 (0x40800000,0x40A00000,0x41200000,0x41300000), m_last on beat 4.
- mm_done held high after DRAIN for 5 cycles → no s_ready until mm_done falls; second job then proceeds normally.
- MMMUL_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=16, mm_done never asserted → error=1 at cycle 16 of RUN, mm_enable=0, m_valid never asserted, return to LOAD_A.
